// File: rtl/alu_mul_sequencer_if.sv
// Request, result and shared-ALU signals between the decoder/ALU side and the multiply sequencer.
// The master side raises start and supplies the ALU result; the slave side is the sequencer.
interface alu_mul_sequencer_if #(
  parameter int N = 32
);
  logic         start;
  logic         accumulate;
  logic [N-1:0] op_a;
  logic [N-1:0] op_b;
  logic [N-1:0] acc_lo_in;
  logic [N-1:0] acc_hi_in;
  logic         busy;
  logic         done;
  logic [N-1:0] result_lo;
  logic [N-1:0] result_hi;
  logic         res_n;
  logic         res_z;
  logic [N-1:0] alu_a;
  logic [N-1:0] alu_b;
  logic [2:0]   alu_ctl;
  logic         alu_carry;
  logic [N-1:0] alu_result;
  logic [1:0]   alu_cv_flags;

  modport master (
    output start, accumulate, op_a, op_b, acc_lo_in, acc_hi_in, alu_result, alu_cv_flags,
    input  busy, done, result_lo, result_hi, res_n, res_z, alu_a, alu_b, alu_ctl, alu_carry
  );

  modport slave (
    input  start, accumulate, op_a, op_b, acc_lo_in, acc_hi_in, alu_result, alu_cv_flags,
    output busy, done, result_lo, result_hi, res_n, res_z, alu_a, alu_b, alu_ctl, alu_carry
  );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add unsigned multiply(-accumulate) through the shared ALU; done N+1 (N+3 with accumulate) cycles after start.
// No backpressure: start is taken only in IDLE and ignored otherwise; the pipeline stalls on busy.
module alu_mul_sequencer #(
  parameter int N = 32
) (
  input logic             clk,
  input logic             n_reset,
  alu_mul_sequencer_if.slave bus
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_ADC = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_ACC_LO,
    S_ACC_HI,
    S_DONE
  } state_t;

  state_t        state, state_nxt;
  logic [N-1:0]  a_reg, a_nxt;
  logic [N-1:0]  hi, hi_nxt;
  logic [N-1:0]  lo, lo_nxt;
  logic [N-1:0]  acc_lo, acc_lo_nxt;
  logic [N-1:0]  acc_hi, acc_hi_nxt;
  logic          acc_flag, acc_flag_nxt;
  logic          carry_reg, carry_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [N-1:0]  result_lo, result_lo_nxt;
  logic [N-1:0]  result_hi, result_hi_nxt;
  logic          res_n, res_n_nxt;
  logic          res_z, res_z_nxt;

  logic          busy, done;
  logic [N-1:0]  alu_a, alu_b;
  logic [2:0]    alu_ctl;
  logic          alu_carry;
  logic          alu_c;
  logic          alu_v_unused;

  assign alu_c        = bus.alu_cv_flags[1];
  assign alu_v_unused = bus.alu_cv_flags[0];

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state     <= S_IDLE;
      a_reg     <= '0;
      hi        <= '0;
      lo        <= '0;
      acc_lo    <= '0;
      acc_hi    <= '0;
      acc_flag  <= 1'b0;
      carry_reg <= 1'b0;
      count     <= '0;
      result_lo <= '0;
      result_hi <= '0;
      res_n     <= 1'b0;
      res_z     <= 1'b1;
    end else begin
      state     <= state_nxt;
      a_reg     <= a_nxt;
      hi        <= hi_nxt;
      lo        <= lo_nxt;
      acc_lo    <= acc_lo_nxt;
      acc_hi    <= acc_hi_nxt;
      acc_flag  <= acc_flag_nxt;
      carry_reg <= carry_nxt;
      count     <= count_nxt;
      result_lo <= result_lo_nxt;
      result_hi <= result_hi_nxt;
      res_n     <= res_n_nxt;
      res_z     <= res_z_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    a_nxt         = a_reg;
    hi_nxt        = hi;
    lo_nxt        = lo;
    acc_lo_nxt    = acc_lo;
    acc_hi_nxt    = acc_hi;
    acc_flag_nxt  = acc_flag;
    carry_nxt     = carry_reg;
    count_nxt     = count;
    result_lo_nxt = result_lo;
    result_hi_nxt = result_hi;
    res_n_nxt     = res_n;
    res_z_nxt     = res_z;
    busy          = 1'b0;
    done          = 1'b0;
    alu_a         = '0;
    alu_b         = '0;
    alu_ctl       = ALU_ADD;
    alu_carry     = 1'b0;

    case (state)
      S_IDLE: begin
        if (bus.start) begin
          a_nxt        = bus.op_a;
          lo_nxt       = bus.op_b;
          hi_nxt       = '0;
          acc_lo_nxt   = bus.acc_lo_in;
          acc_hi_nxt   = bus.acc_hi_in;
          acc_flag_nxt = bus.accumulate;
          count_nxt    = '0;
          state_nxt    = S_MUL;
        end
      end
      S_MUL: begin
        busy  = 1'b1;
        alu_a = hi;
        alu_b = lo[0] ? a_reg : '0;
        // Partial sum (with its carry) shifts right into hi; its LSB enters lo as multiplier bits retire.
        {hi_nxt, lo_nxt} = {alu_c, bus.alu_result, lo[N-1:1]};
        count_nxt = count + 1'b1;
        if (count == CW'(N - 1)) begin
          state_nxt = acc_flag ? S_ACC_LO : S_DONE;
        end
      end
      S_ACC_LO: begin
        busy      = 1'b1;
        alu_a     = lo;
        alu_b     = acc_lo;
        lo_nxt    = bus.alu_result;
        carry_nxt = alu_c;
        state_nxt = S_ACC_HI;
      end
      S_ACC_HI: begin
        busy      = 1'b1;
        alu_a     = hi;
        alu_b     = acc_hi;
        alu_ctl   = ALU_ADC;
        alu_carry = carry_reg;
        hi_nxt    = bus.alu_result;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Results load on entry to DONE so they are already valid while done is high.
    if (state != S_DONE && state_nxt == S_DONE) begin
      result_lo_nxt = lo_nxt;
      result_hi_nxt = hi_nxt;
      res_n_nxt     = hi_nxt[N-1];
      res_z_nxt     = ~|{hi_nxt, lo_nxt};
    end
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.result_lo = result_lo;
  assign bus.result_hi = result_hi;
  assign bus.res_n     = res_n;
  assign bus.res_z     = res_z;
  assign bus.alu_a     = alu_a;
  assign bus.alu_b     = alu_b;
  assign bus.alu_ctl   = alu_ctl;
  assign bus.alu_carry = alu_carry;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: behavioural ALU plus a 64-bit arithmetic reference for each operation.
module tb_alu_mul_sequencer;
  localparam int N = 32;

  logic clk = 1'b0;
  logic n_reset;
  longint unsigned cyc = 0;
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] prev_res;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  alu_mul_sequencer_if #(.N(N)) bus ();

  alu_mul_sequencer #(.N(N)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  // Shared integer ALU, combinational.
  logic [N:0] alu_sum;
  logic       alu_v;
  always_comb begin
    alu_sum = '0;
    case (bus.alu_ctl)
      3'b000:  alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b};
      3'b100:  alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {{N{1'b0}}, bus.alu_carry};
      3'b001:  alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + 1'b1;
      3'b101:  alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {{N{1'b0}}, bus.alu_carry};
      3'b010:  alu_sum = {1'b0, bus.alu_a & bus.alu_b};
      3'b011:  alu_sum = {1'b0, bus.alu_a | bus.alu_b};
      3'b110:  alu_sum = {1'b0, bus.alu_a ^ bus.alu_b};
      default: alu_sum = '0;
    endcase
    alu_v = (bus.alu_a[N-1] == bus.alu_b[N-1]) && (alu_sum[N-1] != bus.alu_a[N-1]);
  end
  assign bus.alu_result   = alu_sum[N-1:0];
  assign bus.alu_cv_flags = {alu_sum[N], alu_v};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic check_idle(input string tag, input logic [63:0] res);
    check({tag, "_busy"}, {63'd0, bus.busy}, 64'd0);
    check({tag, "_done"}, {63'd0, bus.done}, 64'd0);
    check({tag, "_res"}, {bus.result_hi, bus.result_lo}, res);
    check({tag, "_nz"}, {62'd0, bus.res_n, bus.res_z}, {62'd0, res[63], res == 64'd0});
    check({tag, "_alu_ab"}, {bus.alu_a, bus.alu_b}, 64'd0);
    check({tag, "_alu_ctl"}, {60'd0, bus.alu_ctl, bus.alu_carry}, 64'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic acc, input logic [63:0] addend, input bit pulse);
    logic [63:0] expv;
    int edges;
    bit seen, held_ok, ctl_ok, busy_ok;
    expv = ({32'd0, a} * {32'd0, b}) + (acc ? addend : 64'd0);
    held_ok = 1; ctl_ok = 1; busy_ok = 1; seen = 0; edges = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.accumulate = acc; bus.op_a = a; bus.op_b = b;
    bus.acc_lo_in = addend[31:0]; bus.acc_hi_in = addend[63:32];
    @(posedge clk); #1;
    // Captured copies must be used: scramble the live inputs.
    bus.start = 1'b0; bus.accumulate = ~acc; bus.op_a = $urandom; bus.op_b = $urandom;
    bus.acc_lo_in = $urandom; bus.acc_hi_in = $urandom;
    while (!seen && edges < 100) begin
      if (bus.done) seen = 1;
      else begin
        if (!bus.busy) busy_ok = 0;
        if ({bus.result_hi, bus.result_lo} !== prev_res) held_ok = 0;
        if (!(bus.alu_ctl == 3'b000 || (acc && bus.alu_ctl == 3'b100))) ctl_ok = 0;
        if (pulse && edges == 5) begin
          bus.start = 1'b1; bus.op_a = $urandom; bus.op_b = $urandom; bus.accumulate = $urandom_range(0, 1);
        end else bus.start = 1'b0;
        @(posedge clk); #1;
        edges++;
      end
    end
    bus.start = 1'b0;
    // done seen `edges` edges after the sampling edge k means done is cycle k+edges+1.
    check({tag, "_lat"}, 64'(edges + 1), acc ? 64'(N + 3) : 64'(N + 1));
    check({tag, "_busy_run"}, {63'd0, busy_ok}, 64'd1);
    check({tag, "_held"}, {63'd0, held_ok}, 64'd1);
    check({tag, "_ctl"}, {63'd0, ctl_ok}, 64'd1);
    check({tag, "_res"}, {bus.result_hi, bus.result_lo}, expv);
    check({tag, "_nz"}, {62'd0, bus.res_n, bus.res_z}, {62'd0, expv[63], expv == 64'd0});
    check({tag, "_busy_done"}, {63'd0, bus.busy}, 64'd0);
    @(posedge clk); #1;
    check({tag, "_pulse"}, {62'd0, bus.done, bus.busy}, 64'd0);
    check({tag, "_hold"}, {bus.result_hi, bus.result_lo}, expv);
    prev_res = expv;
  endtask

  initial begin
    n_reset = 1'b0;
    bus.start = 1'b0; bus.accumulate = 1'b0; bus.op_a = '0; bus.op_b = '0;
    bus.acc_lo_in = '0; bus.acc_hi_in = '0;
    prev_res = 64'd0;
    #12;
    check_idle("reset", 64'd0);
    @(negedge clk); n_reset = 1'b1;
    @(posedge clk); #1;

    run_op("mul3x5", 32'd3, 32'd5, 1'b0, 64'd0, 1'b0);
    run_op("mulmax", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'd0, 1'b0);
    run_op("macc_carry", 32'hFFFF_FFFF, 32'd1, 1'b1, 64'd1, 1'b0);
    run_op("zero", 32'd0, 32'h1234_5678, 1'b0, 64'd0, 1'b0);
    run_op("start_ignored", 32'hDEAD_BEEF, 32'h0000_1357, 1'b0, 64'd0, 1'b1);
    run_op("macc_wrap", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);

    // Reset in the middle of MUL, at count 10.
    @(negedge clk);
    bus.start = 1'b1; bus.accumulate = 1'b0; bus.op_a = 32'h1111_2222; bus.op_b = 32'h3333_4444;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    n_reset = 1'b0;
    #1;
    check_idle("midreset", 64'd0);
    @(negedge clk); n_reset = 1'b1;
    prev_res = 64'd0;
    @(posedge clk); #1;
    check_idle("after_reset", 64'd0);
    run_op("post_reset", 32'h0001_0003, 32'h0000_0007, 1'b0, 64'd0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      logic [31:0] ra, rb;
      logic [63:0] radd;
      ra = $urandom;
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 15)) : 32'($urandom);
      radd = {32'($urandom), 32'($urandom)};
      run_op("rand", ra, rb, 1'($urandom_range(0, 1)), radd, $urandom_range(0, 3) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, got timeout expected completion");
    $fatal(1);
  end
endmodule
